// File: rtl/text_buffer.sv
// text_buffer: character-cell frame store feeding the glyph renderer.
//
// Game logic pushes bytes through a valid/ready handshake; the block keeps a
// cursor, handles newline (0x0A), carriage return (0x0D) and backspace (0x08),
// and wraps or scrolls at the bottom line. The display side maps the VGA pixel
// position to a cell and presents the cell's ASCII code plus the in-cell pixel
// offsets, one clock after pix_x/pix_y.
//
// Optional feature macro: TEXT_BUFFER_SCROLL_EN
//   defined   -> advancing past the last row scrolls the screen by one line
//                and clears the new bottom line.
//   undefined -> advancing past the last row wraps the cursor to row 0.
//
// Ports:
//   clk, rst_n         pixel clock, asynchronous active-low reset
//   pix_x, pix_y       current pixel position from VGA timing
//   pix_active         high inside the visible area
//   vga_x, vga_y       registered in-cell pixel offsets (pix_x[2:0], pix_y[3:0])
//   char_ascii         registered character of the addressed cell
//   pix_valid          registered; outputs describe a visible, in-range cell
//   wr_char, wr_valid  incoming character / control code and its valid
//   wr_ready           high when a byte can be accepted (IDLE only)
//   clr                single-cycle clear-screen request
//   cursor_col/row     logical cursor position
module text_buffer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       pix_active,
  output logic [2:0] vga_x,
  output logic [3:0] vga_y,
  output logic [7:0] char_ascii,
  output logic       pix_valid,
  input  logic [7:0] wr_char,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       clr,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  localparam logic [AW-1:0] LAST_CELL  = AW'(CELLS - 1);
  localparam logic [AW-1:0] LAST_COL_A = AW'(COLS - 1);
  localparam logic [6:0]    LAST_COL   = 7'(COLS - 1);
  localparam logic [4:0]    LAST_ROW   = 5'(ROWS - 1);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;

  // Logical-to-physical row mapping: (lrow + top) mod ROWS, both < ROWS.
  function automatic logic [4:0] phys_row(input logic [4:0] lrow, input logic [4:0] t);
    logic [5:0] s;
    s = {1'b0, lrow} + {1'b0, t};
    if (s >= 6'(ROWS)) s = s - 6'(ROWS);
    return s[4:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  logic [7:0]    mem [CELLS];

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [6:0]    cur_col, col_n;
  logic [4:0]    cur_row, row_n;
  logic [4:0]    top, top_n;
  logic [4:0]    clr_row, clr_row_n;
  logic [4:0]    cur_phys;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  assign cur_phys   = phys_row(cur_row, top);
  assign wr_ready   = (state == IDLE);
  assign cursor_col = cur_col;
  assign cursor_row = cur_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR_ALL;
      cnt     <= '0;
      cur_col <= '0;
      cur_row <= '0;
      top     <= '0;
      clr_row <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cur_col <= col_n;
      cur_row <= row_n;
      top     <= top_n;
      clr_row <= clr_row_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    col_n     = cur_col;
    row_n     = cur_row;
    top_n     = top;
    clr_row_n = clr_row;
    we        = 1'b0;
    waddr     = '0;
    wdata     = 8'h20;
    case (state)
      CLEAR_ALL: begin
        we    = 1'b1;
        waddr = cnt;
        if (cnt == LAST_CELL) begin
          state_n = IDLE;
          cnt_n   = '0;
          col_n   = '0;
          row_n   = '0;
          top_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      CLEAR_ROW: begin
        we    = 1'b1;
        waddr = cell_addr(clr_row, cnt[6:0]);
        if (cnt == LAST_COL_A) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          state_n = CLEAR_ALL;
          cnt_n   = '0;
        end else if (wr_valid) begin
          logic adv;
          adv = 1'b0;
          case (wr_char)
            8'h0A: begin
              col_n = '0;
              adv   = 1'b1;
            end
            8'h0D: col_n = '0;
            8'h08: begin
              if (cur_col != '0) begin
                col_n = cur_col - 1'b1;
                we    = 1'b1;
                waddr = cell_addr(cur_phys, cur_col - 1'b1);
              end
            end
            default: begin
              we    = 1'b1;
              waddr = cell_addr(cur_phys, cur_col);
              wdata = wr_char;
              if (cur_col == LAST_COL) begin
                col_n = '0;
                adv   = 1'b1;
              end else begin
                col_n = cur_col + 1'b1;
              end
            end
          endcase
          if (adv) begin
            if (cur_row != LAST_ROW) begin
              row_n = cur_row + 1'b1;
            end else begin
`ifdef TEXT_BUFFER_SCROLL_EN
              // The old top physical row becomes the new (blank) bottom line.
              top_n     = (top == LAST_ROW) ? 5'd0 : top + 1'b1;
              clr_row_n = top;
              state_n   = CLEAR_ROW;
              cnt_n     = '0;
`else
              row_n = '0;
`endif
            end
          end
        end
      end
      default: begin
        state_n = CLEAR_ALL;
        cnt_n   = '0;
      end
    endcase
  end

  // Display address (combinational). pix_y[9] set means a row index >= 32,
  // which is always out of range.
  logic [6:0]    disp_col;
  logic [4:0]    disp_row;
  logic          disp_vld;
  logic [AW-1:0] rd_addr;

  assign disp_col = pix_x[9:3];
  assign disp_row = pix_y[8:4];
  assign disp_vld = pix_active && !pix_y[9] && (32'(disp_col) < COLS) && (32'(disp_row) < ROWS);
  assign rd_addr  = disp_vld ? cell_addr(phys_row(disp_row, top), disp_col) : '0;

  // ---- stage p1: memory read and display registers ----
  logic [7:0] rd_data_p1;
  logic [2:0] vga_x_p1;
  logic [3:0] vga_y_p1;
  logic       vld_p1;

  // Write and read share one edge; non-blocking update gives read-old-data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data_p1 <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_x_p1 <= '0;
      vga_y_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vga_x_p1 <= pix_x[2:0];
      vga_y_p1 <= pix_y[3:0];
      vld_p1   <= disp_vld;
    end
  end

  assign vga_x      = vga_x_p1;
  assign vga_y      = vga_y_p1;
  assign pix_valid  = vld_p1;
  assign char_ascii = vld_p1 ? rd_data_p1 : 8'h20;

endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: directed self-checking bench for text_buffer (COLS=80,
// ROWS=30). Scroll expectations follow TEXT_BUFFER_SCROLL_EN.
module tb_text_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       pix_active;
  logic [2:0] vga_x;
  logic [3:0] vga_y;
  logic [7:0] char_ascii;
  logic       pix_valid;
  logic [7:0] wr_char;
  logic       wr_valid;
  logic       wr_ready;
  logic       clr;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;

  int checks = 0;
  int errors = 0;

  text_buffer #(.COLS(80), .ROWS(30)) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
    .vga_x(vga_x), .vga_y(vga_y), .char_ascii(char_ascii), .pix_valid(pix_valid),
    .wr_char(wr_char), .wr_valid(wr_valid), .wr_ready(wr_ready), .clr(clr),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_cell(input int c, input int r, output logic [7:0] ch, output logic v);
    pix_x      = 10'(c * 8 + 5);
    pix_y      = 10'(r * 16 + 9);
    pix_active = 1'b1;
    tick();
    ch = char_ascii;
    v  = pix_valid;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    while (!wr_ready && n < 5000) begin
      tick();
      n++;
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      $display("FAIL send_ready: wr_ready=%b required 1 within 5000 cycles", wr_ready);
      errors++;
    end
    wr_char  = b;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (!wr_ready && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_cursor(input string name, input int c, input int r);
    checks++;
    if (cursor_col !== 7'(c) || cursor_row !== 5'(r)) begin
      $display("FAIL %s: cursor=(%0d,%0d) required (%0d,%0d)", name, cursor_col, cursor_row, c, r);
      errors++;
    end
  endtask

  task automatic chk_cell(input string name, input int c, input int r, input logic [7:0] exp);
    logic [7:0] ch;
    logic       v;
    read_cell(c, r, ch, v);
    checks++;
    if (ch !== exp || v !== 1'b1) begin
      $display("FAIL %s: cell(%0d,%0d)=%h valid=%b required %h valid=1", name, c, r, ch, v, exp);
      errors++;
    end
  endtask

  task automatic test_reset();
    int n;
    int bad;
    logic [7:0] ch;
    logic v;
    rst_n = 1'b0; pix_x = 10'd3; pix_y = 10'd5; pix_active = 1'b1;
    wr_char = 8'h00; wr_valid = 1'b0; clr = 1'b0;
    repeat (3) tick();
    checks++;
    if (vga_x !== 3'd0 || vga_y !== 4'd0 || char_ascii !== 8'h20 || pix_valid !== 1'b0) begin
      $display("FAIL reset_display: vga_x=%0d vga_y=%0d char=%h valid=%b required 0 0 20 0",
               vga_x, vga_y, char_ascii, pix_valid);
      errors++;
    end
    checks++;
    if (wr_ready !== 1'b0) begin
      $display("FAIL reset_ready: wr_ready=%b required 0", wr_ready);
      errors++;
    end
    chk_cursor("reset_cursor", 0, 0);
    rst_n = 1'b1;
    count_busy(n);
    checks++;
    if (n != 2400) begin
      $display("FAIL reset_clear_len: wr_ready rose after %0d clocks required 2400", n);
      errors++;
    end
    chk_cursor("post_clear_cursor", 0, 0);
    bad = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) begin
        read_cell(c, r, ch, v);
        if (ch !== 8'h20 || v !== 1'b1) bad++;
      end
    checks++;
    if (bad != 0) begin
      $display("FAIL screen_blank: %0d cells not 0x20, required 0", bad);
      errors++;
    end
  endtask

  task automatic test_write_a();
    send(8'h41);
    chk_cursor("write_a_cursor", 1, 0);
    pix_x = 10'd3; pix_y = 10'd5; pix_active = 1'b1;
    tick();
    checks++;
    if (vga_x !== 3'd3 || vga_y !== 4'd5 || char_ascii !== 8'h41 || pix_valid !== 1'b1) begin
      $display("FAIL write_a_display: vga_x=%0d vga_y=%0d char=%h valid=%b required 3 5 41 1",
               vga_x, vga_y, char_ascii, pix_valid);
      errors++;
    end
  endtask

  task automatic test_wrap_backspace();
    send(8'h0D);
    chk_cursor("cr_col0", 0, 0);
    repeat (80) send(8'h42);
    chk_cursor("wrap_80", 0, 1);
    chk_cell("wrap_last_cell", 79, 0, 8'h42);
    chk_cell("wrap_first_cell", 0, 0, 8'h42);
    send(8'h08);
    chk_cursor("bs_at_col0", 0, 1);
    send(8'h43);
    chk_cursor("write_c", 1, 1);
    chk_cell("cell_c", 0, 1, 8'h43);
    send(8'h08);
    chk_cursor("bs_after_c", 0, 1);
    chk_cell("bs_blanked", 0, 1, 8'h20);
  endtask

  task automatic test_cr_lf();
    send(8'h44);
    chk_cursor("write_d", 1, 1);
    send(8'h0D);
    chk_cursor("cr", 0, 1);
    send(8'h0A);
    chk_cursor("lf", 0, 2);
  endtask

  task automatic test_bottom_line();
    int n;
    repeat (27) send(8'h0A);
    chk_cursor("lf_to_bottom", 0, 29);
    send(8'h0A);
    count_busy(n);
`ifdef TEXT_BUFFER_SCROLL_EN
    checks++;
    if (n != 80) begin
      $display("FAIL scroll_busy: wr_ready low %0d cycles required 80", n);
      errors++;
    end
    chk_cursor("scroll_cursor", 0, 29);
    chk_cell("scroll_row0", 0, 0, 8'h44);
    chk_cell("scroll_bottom_cleared", 0, 29, 8'h20);
`else
    checks++;
    if (n != 0) begin
      $display("FAIL wrap_busy: wr_ready low %0d cycles required 0", n);
      errors++;
    end
    chk_cursor("wrap_cursor", 0, 0);
    chk_cell("wrap_row0", 0, 0, 8'h42);
    chk_cell("wrap_row1", 0, 1, 8'h44);
`endif
  endtask

  task automatic test_out_of_range();
    pix_x = 10'd640; pix_y = 10'd0; pix_active = 1'b1;
    tick();
    checks++;
    if (char_ascii !== 8'h20 || pix_valid !== 1'b0 || vga_x !== 3'd0) begin
      $display("FAIL col_oob: char=%h valid=%b vga_x=%0d required 20 0 0", char_ascii, pix_valid, vga_x);
      errors++;
    end
    pix_x = 10'd2; pix_y = 10'd480; pix_active = 1'b1;
    tick();
    checks++;
    if (char_ascii !== 8'h20 || pix_valid !== 1'b0) begin
      $display("FAIL row_oob: char=%h valid=%b required 20 0", char_ascii, pix_valid);
      errors++;
    end
    pix_x = 10'd2; pix_y = 10'd2; pix_active = 1'b0;
    tick();
    checks++;
    if (char_ascii !== 8'h20 || pix_valid !== 1'b0) begin
      $display("FAIL inactive: char=%h valid=%b required 20 0", char_ascii, pix_valid);
      errors++;
    end
    pix_active = 1'b1;
  endtask

  task automatic test_clr();
    int n;
    clr = 1'b1; wr_valid = 1'b1; wr_char = 8'h5A;
    tick();
    clr = 1'b0; wr_valid = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      $display("FAIL clr_enter: wr_ready=%b required 0", wr_ready);
      errors++;
    end
    // A clr pulse mid-clear must not restart the sweep.
    n = 0;
    while (!wr_ready && n < 3000) begin
      clr = (n == 100);
      tick();
      n++;
    end
    clr = 1'b0;
    checks++;
    if (n != 2400) begin
      $display("FAIL clr_len: wr_ready low %0d cycles required 2400", n);
      errors++;
    end
    chk_cursor("clr_cursor", 0, 0);
    chk_cell("clr_cell00", 0, 0, 8'h20);
    chk_cell("clr_cell01", 0, 1, 8'h20);
  endtask

  task automatic test_reset_mid();
    int n;
    send(8'h51);
    chk_cursor("pre_reset_write", 1, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b0 || cursor_col !== 7'd0 || pix_valid !== 1'b0) begin
      $display("FAIL async_reset: wr_ready=%b col=%0d valid=%b required 0 0 0", wr_ready, cursor_col, pix_valid);
      errors++;
    end
    tick();
    tick();
    rst_n = 1'b1;
    count_busy(n);
    checks++;
    if (n != 2400) begin
      $display("FAIL reset_restart_len: wr_ready low %0d cycles required 2400", n);
      errors++;
    end
    chk_cell("reset_cleared", 0, 0, 8'h20);
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_wrap_backspace();
    test_cr_lf();
    test_bottom_line();
    test_out_of_range();
    test_clr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_buffer.md
# text_buffer

Character-cell frame store that sits directly upstream of the glyph renderer. It accepts a byte stream of characters from game logic through a valid/ready handshake and maintains a cursor, newline/backspace handling and hardware scrolling. On the display side it maps the VGA pixel position to a cell and presents the cell's ASCII code together with the in-cell pixel offsets. The glyph renderer consumes those three values (3-bit column offset, 4-bit row offset, 8-bit ASCII) to produce one monochrome pixel.

## Interface
Parameters:
- COLS, 80, text columns; cell width fixed at 8 px
- ROWS, 30, text rows; cell height fixed at 16 px

Ports:
- clk  in  1  pixel clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- pix_x  in  10  current pixel column from VGA timing
- pix_y  in  10  current pixel row from VGA timing
- pix_active  in  1  high inside visible area
- vga_x  out  3  registered pix_x[2:0]
- vga_y  out  4  registered pix_y[3:0]
- char_ascii  out  8  registered cell character
- pix_valid  out  1  registered; outputs describe a visible, in-range cell
- wr_char  in  8  character or control code
- wr_valid  in  1  wr_char is valid
- wr_ready  out  1  block accepts wr_char this cycle
- clr  in  1  clear-screen request, single-cycle pulse
- cursor_col  out  7  logical cursor column
- cursor_row  out  5  logical cursor row

## Operation
- Storage: COLS*ROWS bytes, dual-port. One write port is used by the FSM. One synchronous read port is used by the display.
- Register `top` (0..ROWS-1) maps rows: physical = (logical + top) mod ROWS.
- FSM states:
  - CLEAR_ALL: writes 0x20 to every cell, one per cycle, COLS*ROWS cycles. Then cursor = (0,0), top = 0, go to IDLE.
  - IDLE: wr_ready = 1.
  - CLEAR_ROW: writes 0x20 to COLS cells of one physical row, then goes to IDLE.
- wr_ready is high only in IDLE.
- In IDLE, clr takes priority over wr_valid. clr enters CLEAR_ALL and no character is accepted that cycle.
- clr is ignored outside IDLE.
- Accepted byte (wr_valid && wr_ready):
  - 0x0A: col = 0, then advance row.
  - 0x0D: col = 0.
  - 0x08: if col > 0, col = col-1 and write 0x20 at the new position; else no effect.
  - Any other byte: written at (cursor_row, cursor_col). col = col+1. If col was COLS-1, col = 0 and advance row.
- Advance row:
  - If row < ROWS-1: row = row+1.
  - Otherwise the behaviour is set by configuration (see below).
- Display path:
  - Cell column = pix_x[9:3], logical row = pix_y[8:4].
  - The read address is formed combinationally and the data is registered.
  - If !pix_active, column ≥ COLS, or row ≥ ROWS: char_ascii = 0x20 and pix_valid = 0.
- Read/write to the same cell in the same cycle returns the old data.

## Timing
- Reset values:
  - vga_x = 0, vga_y = 0, char_ascii = 0x20, pix_valid = 0
  - wr_ready = 0, cursor_col = 0, cursor_row = 0, top = 0
  - State = CLEAR_ALL
- After rst_n deasserts, wr_ready rises after exactly COLS*ROWS clocks (2400 by default).
- Display latency:
  - vga_x, vga_y, char_ascii and pix_valid are all aligned one clock after pix_x/pix_y.
  - The display path runs in every state. During clears it shows whatever is currently in memory.
- A character write is visible on the read port from the cycle after acceptance.
- Cursor outputs update on the clock edge that accepts the byte.
- CLEAR_ROW keeps wr_ready low for exactly COLS cycles.
- rst_n asserted mid-clear or mid-write aborts immediately and restarts CLEAR_ALL.
- Memory contents are never assumed valid after reset.

## Configuration
- TEXT_BUFFER_SCROLL_EN defined: advance row at ROWS-1 keeps row = ROWS-1, sets top = (top+1) mod ROWS, and enters CLEAR_ROW for the old top physical row, which becomes the new bottom line.
- TEXT_BUFFER_SCROLL_EN undefined: advance row at ROWS-1 sets row = 0. There is no clear and `top` stays 0.

## Test plan
- Reset: release rst_n -> wr_ready low for 2400 clocks, then high. Every visible cell reads 0x20, cursor = (0,0).
- Write 'A' (0x41) -> cursor (1,0). pix_x = 3, pix_y = 5 with pix_active -> one clock later vga_x = 3, vga_y = 5, char_ascii = 0x41, pix_valid = 1.
- Write 80 × 'B' -> cursor (0,1). Write 0x08 at col 0 -> no change. Write 'C' then 0x08 -> cursor (0,1) and cell (0,1) = 0x20.
- SCROLL_EN: 30 × 0x0A from (0,0) -> row stays 29, wr_ready low for 80 cycles, top = 1. The text formerly on logical row 1 now appears on logical row 0. Without the macro -> cursor (0,0), top = 0.
- pix_x = 640 or pix_active = 0 -> char_ascii = 0x20, pix_valid = 0. clr asserted together with wr_valid in IDLE -> character dropped, 2400-cycle clear, cursor (0,0).
